fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, number of instruction buffer entries; it is a power of two and at least 2.
REQ-003 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 Port imem_req_valid, output, 1 bit, fetch request to instruction memory.
REQ-006 Port imem_req_ready, input, 1 bit, memory accepts the request this cycle.
REQ-007 Port imem_req_addr, output, 32 bits, word-aligned fetch address.
REQ-008 Port imem_rsp_valid, input, 1 bit, response data valid; responses return in request order, one per accepted request, no earlier than the cycle after acceptance.
REQ-009 Port imem_rsp_data, input, 32 bits, fetched instruction word.
REQ-010 Port redirect_valid, input, 1 bit, one-cycle pulse from branch/jump resolution.
REQ-011 Port redirect_pc, input, 32 bits, new fetch target; bits [1:0] are ignored (treated as 0).
REQ-012 Port instr_valid, output, 1 bit, instruction available to the decode stage.
REQ-013 Port instr_ready, input, 1 bit, decode accepts the instruction this cycle.
REQ-014 Port instr_data, output, 32 bits, raw RV32I instruction word for decode.
REQ-015 Port instr_pc, output, 32 bits, address instr_data was fetched from.

Function
REQ-016 A fetch_pc register holds the next fetch address; it advances by 4 on each accepted request (imem_req_valid && imem_req_ready) and wraps modulo 2^32.
REQ-017 The buffer entry is reserved at request acceptance: the entry's pc is written with imem_req_addr and its filled flag is cleared.
REQ-018 imem_req_valid = 1 only when a free entry exists (reserved count < DEPTH) and redirect_valid = 0.
REQ-019 Once asserted without ready, imem_req_valid stays high and imem_req_addr stays stable until acceptance, except when a redirect withdraws it.
REQ-020 A response with drop_count = 0 fills the oldest unfilled reserved entry with imem_rsp_data and sets its filled flag.
REQ-021 instr_valid = filled flag of the head entry, and instr_data/instr_pc are the head entry's fields, driven from registers.
REQ-022 On instr_valid && instr_ready, the head entry is freed and the head pointer advances modulo DEPTH.
REQ-023 A freed entry may be re-reserved in the same cycle (full buffer plus pop plus accept is legal); a full buffer with no pop blocks requests.
REQ-024 Latency: request accepted in cycle N, response in cycle N+1 -> instr_valid in cycle N+2.
REQ-025 With single-cycle memory, ready=1 and no redirects, throughput is one instruction per cycle for DEPTH >= 2.
REQ-026 On redirect_valid the following happen in that cycle: all entries are cleared (instr_valid = 0 next cycle), fetch_pc <= {redirect_pc[31:2],2'b00}, and drop_count <= the number of requests accepted but not yet responded.
REQ-027 A request accepted in the redirect cycle cannot occur (REQ-018), so it is not counted.
REQ-028 A response arriving while drop_count > 0 is discarded and decrements drop_count.
REQ-029 A response arriving in the redirect cycle is discarded and is included in the new drop_count.
REQ-030 An instruction handshake in the redirect cycle completes for the consumer, but its entry is flushed regardless.
REQ-031 A redirect arriving while drop_count > 0 sets drop_count to the total in-flight count.
REQ-032 Requests to the redirect target start in the cycle after the redirect, concurrently with draining.
REQ-033 Counters are sized for 0..DEPTH inclusive and never over- or underflow under legal memory behaviour.

Reset
REQ-034 While rst = 1, outputs are held as follows: imem_req_valid = 0, imem_req_addr = RESET_PC, instr_valid = 0, instr_data = 0, instr_pc = 0.
REQ-035 While rst = 1, fetch_pc = RESET_PC, all entries are empty, drop_count = 0, and pointers = 0.
REQ-036 The first request is asserted in the first cycle after rst deasserts.
REQ-037 Reset mid-operation discards all buffered and in-flight state; responses for pre-reset requests are the memory's responsibility to suppress.

Verification
REQ-038 Reset release, ready=1, 1-cycle memory returning addr^32'hA5A5_0000, instr_ready=1 -> instr_pc sequence 0, 4, 8, 12 on consecutive cycles, starting cycle 2 after release, with matching data.
REQ-039 instr_ready=0 for 10 cycles -> exactly DEPTH requests issued (addresses 0, 4), imem_req_valid low thereafter; on ready=1, delivery resumes in order with no gap or duplicate.
REQ-040 imem_req_ready held 0 for 3 cycles with a request pending -> imem_req_addr stable at 0 for all 3 cycles; advances to 4 only after acceptance.
REQ-041 Redirect to 32'h0000_0103 with 2 responses outstanding -> both responses discarded, next request address 32'h0000_0100, next instr_pc 32'h0000_0100.
REQ-042 Redirect coincident with a response and an instr handshake, then a second redirect one cycle later -> only the second target's instructions are delivered; drop_count returns to 0.
REQ-043 Wrap-around: RESET_PC = 32'hFFFF_FFFC -> instr_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a reservation buffer and redirect flush/drop handling
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 4;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [AW-1:0] head, tail, fill;
  logic [AW:0]   cnt, uf;
  logic [DW-1:0] drop;
  logic          acc, pop, take;
  assign instr_valid    = filled[head];
  assign instr_data     = data_q[head];
  assign instr_pc       = pc_q[head];
  assign pop            = instr_valid && instr_ready;
  // a popping full buffer frees the slot the new request reserves
  assign imem_req_valid = !rst && !redirect_valid && (cnt < (AW+1)'(DEPTH) || pop);
  assign imem_req_addr  = fetch_pc;
  assign acc            = imem_req_valid && imem_req_ready;
  assign take           = imem_rsp_valid && drop == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      filled   <= '0;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      cnt      <= '0;
      uf       <= '0;
      drop     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      filled   <= '0;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      cnt      <= '0;
      uf       <= '0;
      drop     <= drop + DW'(uf) - DW'(imem_rsp_valid);
    end else begin
      if (imem_rsp_valid && drop != '0)
        drop <= drop - DW'(1);
      if (take) begin
        data_q[fill] <= imem_rsp_data;
        filled[fill] <= 1'b1;
        fill         <= fill + AW'(1);
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + AW'(1);
      end
      if (acc) begin
        pc_q[tail]   <= fetch_pc;
        filled[tail] <= 1'b0;
        tail         <= tail + AW'(1);
        fetch_pc     <= fetch_pc + 32'd4;
      end
      cnt <= cnt + (AW+1)'(acc) - (AW+1)'(pop);
      uf  <= uf + (AW+1)'(acc) - (AW+1)'(take);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed redirect/wrap sequences and randomized run against a stream model
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk = 0, rst = 1;
  logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0;
  logic        redirect_valid = 0, instr_valid, instr_ready = 0;
  logic [31:0] redirect_pc = 0, instr_data, instr_pc;
  logic        w_rst = 1, w_req_valid, w_rsp_valid = 0, w_instr_valid;
  logic        w_req_ready = 1, w_instr_ready = 1, w_redirect_valid = 0;
  logic [31:0] w_req_addr, w_rsp_data = 0, w_instr_data, w_instr_pc, w_redirect_pc = 0;
  int checks = 0, errors = 0, delivered = 0, mem_mode = 0;
  logic [31:0] mem_q[$];
  logic [31:0] exp_pc = 0, prev_addr = 0;
  logic        prev_wait = 0;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_data;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst), .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .instr_valid(w_instr_valid),
    .instr_ready(w_instr_ready), .instr_data(w_instr_data), .instr_pc(w_instr_pc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one cycle: drive at negedge, let the memory model answer, sample, then update the stream model
  task automatic step(input logic rs, input logic rr, input logic ir, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = rs;
    imem_req_ready = rr;
    instr_ready = ir;
    redirect_valid = rv;
    redirect_pc = rpc;
    if (rs) begin
      mem_q.delete();
      exp_pc = 0;
      prev_wait = 0;
    end
    if (mem_q.size() > 0 && (mem_mode == 0 || (mem_mode == 2 && $urandom_range(1, 0) == 1))) begin
      imem_rsp_valid = 1;
      imem_rsp_data = mem_q.pop_front() ^ K;
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = 0;
    end
    #1;
    s_rv = imem_req_valid;
    s_addr = imem_req_addr;
    s_iv = instr_valid;
    s_pc = instr_pc;
    s_data = instr_data;
    if (rs) return;
    if (rv) chk("req_blocked_by_redirect", {31'd0, s_rv}, 32'd0);
    if (prev_wait && !rv) begin
      chk("req_valid_held", {31'd0, s_rv}, 32'd1);
      chk("req_addr_stable", s_addr, prev_addr);
    end
    prev_wait = s_rv && !rr;
    prev_addr = s_addr;
    if (s_rv && rr) mem_q.push_back(s_addr);
    if (s_iv && ir) begin
      chk("stream_pc", s_pc, exp_pc);
      chk("stream_data", s_data, exp_pc ^ K);
      exp_pc += 4;
      delivered++;
    end
    if (rv) exp_pc = rpc & 32'hFFFF_FFFC;
  endtask

  typedef struct {
    logic rs, rr, ir, erv;
    logic [31:0] ea;
    logic eiv;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rs, rr, ir, erv, input logic [31:0] ea, input logic eiv, input logic [31:0] epc);
    tbl.push_back('{rs, rr, ir, erv, ea, eiv, epc});
  endtask

  initial begin
    int n;
    logic found;
    logic [31:0] got[3];
    logic [31:0] rpc;
    // streaming from reset
    add(1,1,1, 0,0, 0,0);
    add(0,1,1, 1,0, 0,0);  add(0,1,1, 1,4, 0,0);  add(0,1,1, 1,8, 1,0);
    add(0,1,1, 1,12,1,4);  add(0,1,1, 1,16,1,8);  add(0,1,1, 1,20,1,12);
    // consumer stall: only DEPTH requests, then in-order resume
    add(1,1,0, 0,0, 0,0);
    add(0,1,0, 1,0, 0,0);  add(0,1,0, 1,4, 0,0);
    for (int i = 0; i < 8; i++) add(0,1,0, 0,8, 1,0);
    add(0,1,1, 1,8, 1,0);  add(0,1,1, 1,12,1,4);  add(0,1,1, 1,16,1,8);
    // memory not ready: address held
    add(1,0,1, 0,0, 0,0);
    add(0,0,1, 1,0, 0,0);  add(0,0,1, 1,0, 0,0);  add(0,0,1, 1,0, 0,0);
    add(0,1,1, 1,0, 0,0);  add(0,1,1, 1,4, 0,0);  add(0,1,1, 1,8, 1,0);
    mem_mode = 0;
    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].rr, tbl[i].ir, 1'b0, 32'd0);
      chk($sformatf("vec%0d_req_valid", i), {31'd0, s_rv}, {31'd0, tbl[i].erv});
      chk($sformatf("vec%0d_req_addr", i), s_addr, tbl[i].ea);
      chk($sformatf("vec%0d_instr_valid", i), {31'd0, s_iv}, {31'd0, tbl[i].eiv});
      chk($sformatf("vec%0d_instr_pc", i), s_pc, tbl[i].epc);
      if (tbl[i].eiv) chk($sformatf("vec%0d_instr_data", i), s_data, tbl[i].epc ^ K);
    end
    // redirect with two responses outstanding
    step(1,1,1,0,0);
    mem_mode = 1;
    step(0,1,1,0,0);
    step(0,1,1,0,0);
    step(0,1,1,0,0);
    chk("full_blocks_req", {31'd0, s_rv}, 32'd0);
    step(0,1,1,1,32'h0000_0103);
    mem_mode = 0;
    step(0,1,1,0,0);
    chk("redirect_req_valid", {31'd0, s_rv}, 32'd1);
    chk("redirect_req_addr", s_addr, 32'h0000_0100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0,1,1,0,0);
      if (s_iv) begin
        found = 1;
        chk("redirect_first_pc", s_pc, 32'h0000_0100);
      end
    end
    chk("redirect_delivered", {31'd0, found}, 32'd1);
    // back-to-back redirects coincident with response and handshake
    step(1,1,1,0,0);
    for (int i = 0; i < 5; i++) step(0,1,1,0,0);
    chk("steady_rsp", {31'd0, imem_rsp_valid}, 32'd1);
    chk("steady_pop", {31'd0, s_iv}, 32'd1);
    step(0,1,1,1,32'h0000_0200);
    step(0,1,1,1,32'h0000_0300);
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      step(0,1,1,0,0);
      if (s_iv) begin
        got[n] = s_pc;
        n++;
      end
    end
    chk("double_redirect_count", n, 3);
    for (int i = 0; i < n; i++) chk($sformatf("double_redirect_pc%0d", i), got[i], 32'h300 + 32'(4 * i));
    for (int i = 0; i < 8; i++) step(0,1,1,0,0);
    // randomized run against the stream model
    mem_mode = 2;
    step(1,1,1,0,0);
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom;
      step(0, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, rpc);
    end
    chk("random_progress", {31'd0, delivered > 200}, 32'd1);
    // address wrap from the top of memory
    n = 0;
    found = 0;
    rpc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) w_rst = 0;
      w_rsp_valid = found;
      w_rsp_data = rpc ^ K;
      #1;
      if (w_instr_valid && n < 3) begin
        got[n] = w_instr_pc;
        chk("wrap_data", w_instr_data, w_instr_pc ^ K);
        n++;
      end
      found = w_req_valid;
      rpc = w_req_addr;
    end
    chk("wrap_count", n, 3);
    chk("wrap_pc0", got[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", got[1], 32'h0000_0000);
    chk("wrap_pc2", got[2], 32'h0000_0004);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
